// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-ported ARM register file.
package regfile_pkg;

  localparam int RF_WIDTH = 32;
  localparam int RF_NREGS = 16;
  localparam int RF_NRD   = 3;
  // PC index for the default geometry; parametrised instances derive their own.
  localparam int PC_IDX   = RF_NREGS - 1;

  // Low bit of port `port` within a packed bus of `w`-bit lanes.
  function automatic int slice_lo(input int port, input int w);
    return port * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: reserve at issue, clear at write-back, busy per read port.
// Busy and pend_cnt visible 1 cycle after issue; no backpressure (REGFILE_MP_BYPASS_EN masks busy on write-back).
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = RF_NRD,
  parameter int AW    = $clog2(RF_NREGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_a,
  input  logic              iss_long,
  input  logic [AW-1:0]     iss_a_hi,
  input  logic              we3,
  input  logic [AW-1:0]     a3,
  input  logic              we4,
  input  logic [AW-1:0]     a4,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]    rd_busy,
  output logic [AW:0]       pend_cnt
);

  localparam logic [AW-1:0] PC_A = AW'(NREGS - 1);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pend_nxt;
  logic [AW:0]      cnt_nxt;

  // Clears are applied first so a same-edge reservation overrides them.
  always_comb begin
    pend_nxt = pending;
    if (we3 && a3 < PC_A) pend_nxt[a3] = 1'b0;
    if (we4 && a4 < PC_A) pend_nxt[a4] = 1'b0;
    if (iss_valid && iss_a < PC_A) pend_nxt[iss_a] = 1'b1;
    if (iss_valid && iss_long && iss_a_hi < PC_A) pend_nxt[iss_a_hi] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREGS; r++) cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[r]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic [AW-1:0] rai;
    assign rai = ra[slice_lo(i, AW) +: AW];
    always_comb begin
      rd_busy[i] = (rai < PC_A) && pending[rai];
`ifdef REGFILE_MP_BYPASS_EN
      if ((we3 && a3 == rai) || (we4 && a4 == rai)) rd_busy[i] = 1'b0;
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported ARM register file: NRD comb reads, two write ports, r15 external, pending scoreboard.
// Write-to-read 1 cycle (0 with REGFILE_MP_BYPASS_EN); no backpressure, readers see stall instead.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = RF_NRD,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we3,
  input  logic [AW-1:0]        a3,
  input  logic [WIDTH-1:0]     wd3,
  input  logic                 we4,
  input  logic [AW-1:0]        a4,
  input  logic [WIDTH-1:0]     wd4,
  input  logic [WIDTH-1:0]     r15,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_a,
  input  logic                 iss_long,
  input  logic [AW-1:0]        iss_a_hi,
  output logic [NRD-1:0]       rd_busy,
  output logic                 stall,
  output logic [AW:0]          pend_cnt
);

  localparam logic [AW-1:0] PC_A = AW'(NREGS - 1);

  logic [WIDTH-1:0] mem [NREGS-1];

  // Port 4 is written last so it wins a same-address double write (RdHi over RdLo).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS - 1; r++) mem[r] <= '0;
    end else begin
      if (we3 && a3 < PC_A) mem[a3] <= wd3;
      if (we4 && a4 < PC_A) mem[a4] <= wd4;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    rai;
    logic [WIDTH-1:0] rdv;
    assign rai = ra[slice_lo(i, AW) +: AW];
    always_comb begin
      rdv = '0;
      if (rai == PC_A) begin
        rdv = r15;
      end else if (rai < PC_A) begin
        rdv = mem[rai];
`ifdef REGFILE_MP_BYPASS_EN
        if (we3 && a3 == rai) rdv = wd3;
        if (we4 && a4 == rai) rdv = wd4;
`endif
      end
    end
    assign rd[slice_lo(i, WIDTH) +: WIDTH] = rdv;
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .AW    (AW)
  ) u_sb (
    .clk       (clk),
    .reset_n   (reset_n),
    .iss_valid (iss_valid),
    .iss_a     (iss_a),
    .iss_long  (iss_long),
    .iss_a_hi  (iss_a_hi),
    .we3       (we3),
    .a3        (a3),
    .we4       (we4),
    .a4        (a4),
    .ra        (ra),
    .rd_busy   (rd_busy),
    .pend_cnt  (pend_cnt)
  );

  assign stall = |rd_busy;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised, multi-ported ARM register file for the multi-cycle/pipelined core.
- Generalises the single-cycle file:
  - configurable width, register count and read-port count;
  - two independent write ports, so long multiplies (UMULL/SMULL) retire both halves in one cycle;
  - r15 is supplied externally as PC+8.
- Adds reset and a pending-write scoreboard. Multi-cycle units (multiplier) reserve destinations at issue, and readers get a stall indication until the result is written back.

Parameters:
- WIDTH, 32, data width of each register.
- NREGS, 16, architectural registers including PC; index NREGS-1 is the PC and is not stored.
- NRD, 3, number of read ports (Rn, Rm, Rs).
- AW, $clog2(NREGS), register address width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- we3  in  1  write enable, port 3.
- a3  in  AW  write address, port 3.
- wd3  in  WIDTH  write data, port 3.
- we4  in  1  write enable, port 4 (RdHi of long multiply).
- a4  in  AW  write address, port 4.
- wd4  in  WIDTH  write data, port 4.
- r15  in  WIDTH  PC+8, returned for reads of index NREGS-1.
- ra  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd  out  NRD*WIDTH  packed read data.
- iss_valid  in  1  reserve destinations of an issuing multi-cycle op.
- iss_a  in  AW  primary destination to reserve.
- iss_long  in  1  also reserve iss_a_hi.
- iss_a_hi  in  AW  second destination (long op).
- rd_busy  out  NRD  per read port: the addressed register is pending.
- stall  out  1  OR of rd_busy.
- pend_cnt  out  AW+1  number of pending registers.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - all stored registers cleared to 0, all pending bits cleared, pend_cnt=0.
  - Outputs are combinational from this state: rd shows 0 (or r15 for the PC index); rd_busy=0; stall=0.
  - Reset mid-operation discards every reservation; a later write-back to a no-longer-pending register is an ordinary write.
- Writes:
  - take effect on the rising clk edge.
  - Writes to index NREGS-1 are ignored; the PC lives outside this block.
  - we3 and we4 to the same address in the same cycle: wd4 is stored.
- Reads:
  - combinational.
  - Index NREGS-1 returns r15 and never asserts rd_busy.
  - Any other index returns the stored value.
  - Without the optional feature, a read in the same cycle as a write to that register returns the old value.
- Scoreboard:
  - one pending bit per stored register.
  - On a clock edge with iss_valid=1, set pending[iss_a]; if iss_long=1, also set pending[iss_a_hi].
  - Reservations of the PC index are ignored.
  - A write with we3 (a3) or we4 (a4) clears the pending bit of that address.
  - Set and clear of the same bit on the same edge: set wins (new reservation).
  - Reserving an already-pending register leaves it pending; pend_cnt does not double count.
- rd_busy[i] = pending[ra_i] and ra_i != NREGS-1.
  - In the same cycle as the clearing write, the result depends on the optional feature.
- pend_cnt:
  - registered popcount of pending, updated on the same edge as pending.
  - Range 0..NREGS-1; no wrap possible.
- Latency:
  - write-to-read 1 cycle without bypass;
  - issue-to-busy 1 cycle (visible the cycle after iss_valid).

Optional Feature:
- Macro REGFILE_MP_BYPASS_EN.
- When defined:
  - a read whose address matches an active write this cycle returns the write data (wd4 has priority over wd3 on a double match);
  - rd_busy is suppressed for that port, because the pending result is arriving now.
  - Zero-latency write-to-read.
- When undefined: old stored value is returned and rd_busy stays asserted until the edge clears the bit.
- PC index is unaffected either way.

Decomposition:
- Package regfile_pkg:
  - default WIDTH/NREGS/NRD;
  - localparam PC_IDX = NREGS-1;
  - function for the packed port slice.
- One sub-module rf_scoreboard:
  - holds the pending vector and pend_cnt;
  - inputs: issue and write-back addresses/enables;
  - outputs: per-read-port busy.
- regfile_mp instantiates rf_scoreboard and the storage array plus read muxes.

Test Plan:
- Reset with reset_n low asynchronously mid-cycle after writing R1=0xDEADBEEF -> rd for ra=1 reads 0, pend_cnt=0, stall=0 immediately.
- Write R4=0x11, R5=0x22 via we3/we4 in one cycle; next cycle ra0=4, ra1=5, ra2=15 with r15=0x108 -> rd = 0x11, 0x22, 0x108.
- we3/we4 both to R7 with wd3=0xA, wd4=0xB -> R7 reads 0xB. Write to R15 -> no effect, r15 still returned.
- Long op: iss_valid, iss_long, iss_a=2, iss_a_hi=3 -> next cycle pend_cnt=2, ra0=2 gives rd_busy[0]=1 and stall=1. Write-back we3 a3=2 and we4 a4=3 -> following cycle pend_cnt=0, stall=0.
- Issue iss_a=6 and we3 a3=6 on the same edge -> R6 pending afterwards, pend_cnt=1.
- With REGFILE_MP_BYPASS_EN: R9 pending, same cycle we3 a3=9 wd3=0x55, ra0=9 -> rd=0x55, rd_busy[0]=0. Without it -> old value, rd_busy[0]=1.
